// File: rtl/mu0_acc_pkg.sv
// Shared opcode, state and helper definitions for the MU0 accumulator bank.
package mu0_acc_pkg;

  localparam logic [2:0] OPC_NOP  = 3'd0;
  localparam logic [2:0] OPC_LOAD = 3'd1;
  localparam logic [2:0] OPC_ADD  = 3'd2;
  localparam logic [2:0] OPC_SUB  = 3'd3;
  localparam logic [2:0] OPC_AND  = 3'd4;
  localparam logic [2:0] OPC_SHL  = 3'd5;
  localparam logic [2:0] OPC_SHR  = 3'd6;
  localparam logic [2:0] OPC_ASR  = 3'd7;

  typedef enum logic [2:0] {
    OP_NOP  = OPC_NOP,
    OP_LOAD = OPC_LOAD,
    OP_ADD  = OPC_ADD,
    OP_SUB  = OPC_SUB,
    OP_AND  = OPC_AND,
    OP_SHL  = OPC_SHL,
    OP_SHR  = OPC_SHR,
    OP_ASR  = OPC_ASR
  } op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for the opcodes that run through the multi-cycle shift sequence.
  function automatic logic is_shift(input op_t op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/mu0_acc_alu.sv
// Combinational single-cycle ALU for the accumulator bank (LOAD/ADD/SUB/AND).
module mu0_acc_alu
  import mu0_acc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_carry_we,
  output logic             o_ovf_we
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the extended difference is the borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Result and flag selection; NOP and shift opcodes pass the accumulator through untouched.
  always_comb begin
    o_result   = i_a;
    o_carry    = 1'b0;
    o_ovf      = 1'b0;
    o_carry_we = 1'b0;
    o_ovf_we   = 1'b0;
    case (i_op)
      OP_LOAD: o_result = i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_ADD: begin
        o_result   = w_sum[WIDTH-1:0];
        o_carry    = w_sum[WIDTH];
        o_ovf      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
        o_carry_we = 1'b1;
        o_ovf_we   = 1'b1;
      end
      OP_SUB: begin
        o_result   = w_diff[WIDTH-1:0];
        o_carry    = ~w_diff[WIDTH];
        o_ovf      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
        o_carry_we = 1'b1;
        o_ovf_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_acc_bank.sv
// MU0 accumulator bank: NACC accumulators, single-cycle ALU ops, multi-cycle shifts.
// All state changes on the falling edge of clk, like the rest of the MU0 datapath.
//
// Handshake: a command is taken on a falling edge where op_valid && op_ready;
// op_ready is high only in IDLE, commands offered while it is low are dropped
// (not queued), and done is high for exactly the cycle after completion.
module mu0_acc_bank
  import mu0_acc_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NACC  = 4,
  localparam int AW    = (NACC > 1) ? $clog2(NACC) : 1,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    sel,
  input  logic [WIDTH-1:0] operand,
  input  logic [SW-1:0]    shamt,
  input  logic [AW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_n,
  output logic             rd_z,
  output logic             carry,
  output logic             ovf,
  output logic             done,
  output state_t           dbg_state
);

  logic [WIDTH-1:0] r_acc [NACC];
  logic             r_carry;
  logic             r_ovf;
  logic             r_done;
  state_t           r_state;
  logic [SW-1:0]    r_cnt;
  logic [AW-1:0]    r_sel;
  op_t              r_op;

  state_t           w_state_nxt;
  logic             w_done_nxt;
  op_t              w_op;
  logic             w_accept;
  logic             w_sel_ok;
  logic             w_rd_ok;
  logic             w_start_shift;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_ovf;
  logic             w_alu_carry_we;
  logic             w_alu_ovf_we;
  logic [WIDTH-1:0] w_sh_cur;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_carry;

  assign w_op          = op_t'(op);
  assign w_accept      = op_valid && (r_state == ST_IDLE);
  // Out-of-range selects complete as a no-op rather than touching any register.
  assign w_sel_ok      = ({1'b0, sel} < (AW + 1)'(NACC));
  assign w_rd_ok       = ({1'b0, rd_sel} < (AW + 1)'(NACC));
  assign w_start_shift = is_shift(w_op) && (shamt != '0) && w_sel_ok;
  assign w_tgt         = w_sel_ok ? r_acc[sel] : '0;

  mu0_acc_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a        (w_tgt),
    .i_b        (operand),
    .i_op       (w_op),
    .o_result   (w_alu_res),
    .o_carry    (w_alu_carry),
    .o_ovf      (w_alu_ovf),
    .o_carry_we (w_alu_carry_we),
    .o_ovf_we   (w_alu_ovf_we)
  );

  // One-bit shift step on the latched target; carry takes the bit shifted out.
  assign w_sh_cur = r_acc[r_sel];
  always_comb begin
    w_sh_next  = w_sh_cur;
    w_sh_carry = r_carry;
    case (r_op)
      OP_SHL: {w_sh_carry, w_sh_next} = {w_sh_cur, 1'b0};
      OP_SHR: {w_sh_next, w_sh_carry} = {1'b0, w_sh_cur};
      OP_ASR: {w_sh_next, w_sh_carry} = {w_sh_cur[WIDTH-1], w_sh_cur};
      default: ;
    endcase
  end

  // Next-state and done-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_start_shift) w_state_nxt = ST_SHIFT;
          else               w_done_nxt  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_cnt <= SW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and done register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Accumulator array, flags and shift bookkeeping.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NACC; i++) r_acc[i] <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_op    <= OP_NOP;
    end else if (w_accept && w_sel_ok) begin
      if (w_start_shift) begin
        r_cnt <= shamt;
        r_sel <= sel;
        r_op  <= w_op;
      end else begin
        r_acc[sel] <= w_alu_res;
        if (w_alu_carry_we) r_carry <= w_alu_carry;
        if (w_alu_ovf_we)   r_ovf   <= w_alu_ovf;
      end
    end else if (r_state == ST_SHIFT) begin
      r_acc[r_sel] <= w_sh_next;
      r_carry      <= w_sh_carry;
      r_cnt        <= r_cnt - SW'(1);
    end
  end

  assign op_ready  = (r_state == ST_IDLE);
  assign rd_data   = w_rd_ok ? r_acc[rd_sel] : '0;
  assign rd_n      = rd_data[WIDTH-1];
  assign rd_z      = (rd_data == '0);
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mu0_acc_bank.sv
// Directed bench for mu0_acc_bank (WIDTH=16, NACC=4); active edge is the falling edge.
module tb_mu0_acc_bank;
  import mu0_acc_pkg::*;

  localparam int WIDTH = 16;
  localparam int NACC  = 4;
  localparam int AW    = 2;
  localparam int SW    = 4;

  logic             clk;
  logic             rst_n;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [AW-1:0]    sel;
  logic [WIDTH-1:0] operand;
  logic [SW-1:0]    shamt;
  logic [AW-1:0]    rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             rd_n;
  logic             rd_z;
  logic             carry;
  logic             ovf;
  logic             done;
  state_t           dbg_state;

  int n_cmp;
  int n_err;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] v;

  mu0_acc_bank #(.WIDTH(WIDTH), .NACC(NACC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .sel       (sel),
    .operand   (operand),
    .shamt     (shamt),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .rd_n      (rd_n),
    .rd_z      (rd_z),
    .carry     (carry),
    .ovf       (ovf),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock: falling edges at 5, 15, 25, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active (falling) edge and settle 1 time unit.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] idx, output logic [WIDTH-1:0] val);
    rd_sel = idx;
    #1;
    val = rd_data;
  endtask

  // Present one command for a single edge.
  task automatic cmd(input logic [2:0] o, input logic [AW-1:0] s,
                     input logic [WIDTH-1:0] d, input logic [SW-1:0] k);
    op = o; sel = s; operand = d; shamt = k; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; op_valid = 1'b0; op = OPC_NOP; sel = '0;
    operand = '0; shamt = '0; rd_sel = '0;

    // Reset state
    #1;
    for (int i = 0; i < NACC; i++) begin
      rd(AW'(i), v);
      check($sformatf("rst_acc%0d", i), v, 16'h0000);
    end
    check("rst_ready", op_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_carry", carry, 1'b0);
    #6 rst_n = 1'b1;
    step();

    // ADD overflow / carry
    cmd(OPC_LOAD, 2, 16'h7FFF, 0);
    check("load_done", done, 1'b1);
    cmd(OPC_ADD, 2, 16'h0001, 0);
    rd(2, v);
    check("add1_val", v, 16'h8000);
    check("add1_carry", carry, 1'b0);
    check("add1_ovf", ovf, 1'b1);
    check("add1_n", rd_n, 1'b1);
    check("add1_done", done, 1'b1);
    cmd(OPC_ADD, 2, 16'h8000, 0);
    rd(2, v);
    check("add2_val", v, 16'h0000);
    check("add2_carry", carry, 1'b1);
    check("add2_ovf", ovf, 1'b1);
    check("add2_z", rd_z, 1'b1);
    check("add2_done", done, 1'b1);
    step();
    check("add_done_end", done, 1'b0);

    // Reset mid-traffic, no clock edge needed
    cmd(OPC_LOAD, 3, 16'h1111, 0);
    check("pre_rst_done", done, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_carry", carry, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    check("mid_rst_ready", op_ready, 1'b1);
    rd(3, v);
    check("mid_rst_acc3", v, 16'h0000);
    rd(2, v);
    check("mid_rst_acc2", v, 16'h0000);
    rst_n = 1'b1;
    step();

    // SUB borrow, AND
    cmd(OPC_LOAD, 1, 16'h0005, 0);
    cmd(OPC_SUB, 1, 16'h0007, 0);
    rd(1, v);
    check("sub_val", v, 16'hFFFE);
    check("sub_carry", carry, 1'b0);
    check("sub_ovf", ovf, 1'b0);
    cmd(OPC_AND, 1, 16'h00F0, 0);
    rd(1, v);
    check("and_val", v, 16'h00F0);
    check("and_carry", carry, 1'b0);
    check("and_ovf", ovf, 1'b0);

    // Flags survive LOAD/AND when set; SUB with no borrow sets carry
    cmd(OPC_LOAD, 2, 16'hFFFF, 0);
    cmd(OPC_ADD, 2, 16'h0001, 0);
    check("addc_carry", carry, 1'b1);
    check("addc_ovf", ovf, 1'b0);
    cmd(OPC_LOAD, 2, 16'h8000, 0);
    check("loadkeep_carry", carry, 1'b1);
    cmd(OPC_SUB, 2, 16'h0001, 0);
    rd(2, v);
    check("sub2_val", v, 16'h7FFF);
    check("sub2_carry", carry, 1'b1);
    check("sub2_ovf", ovf, 1'b1);
    cmd(OPC_AND, 2, 16'h0F0F, 0);
    rd(2, v);
    check("and2_val", v, 16'h0F0F);
    check("and2_ovf", ovf, 1'b1);

    // SHR by 3 with intermediates
    cmd(OPC_LOAD, 0, 16'h8001, 0);
    cmd(OPC_SHR, 0, 16'h0000, 3);
    rd(0, v);
    check("shr_acc_held", v, 16'h8001);
    check("shr_ready0", op_ready, 1'b0);
    check("shr_state", dbg_state, ST_SHIFT);
    check("shr_done0", done, 1'b0);
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h2000);
    exp_q.push_back(16'h1000);
    for (int i = 1; i <= 3; i++) begin
      step();
      rd(0, v);
      check($sformatf("shr_val%0d", i), v, exp_q.pop_front());
      check($sformatf("shr_carry%0d", i), carry, (i == 1) ? 1'b1 : 1'b0);
      check($sformatf("shr_ready%0d", i), op_ready, (i == 3) ? 1'b1 : 1'b0);
      check($sformatf("shr_done%0d", i), done, (i == 3) ? 1'b1 : 1'b0);
    end
    step();
    check("shr_done_end", done, 1'b0);

    // ASR by 15
    cmd(OPC_LOAD, 0, 16'h8000, 0);
    cmd(OPC_ASR, 0, 16'h0000, 15);
    for (int i = 1; i <= 14; i++) step();
    check("asr_ready14", op_ready, 1'b0);
    rd(0, v);
    check("asr_val14", v, 16'hFFFE);
    step();
    rd(0, v);
    check("asr_val", v, 16'hFFFF);
    check("asr_carry", carry, 1'b0);
    check("asr_done", done, 1'b1);

    // Shift by 0 completes in one edge, value and carry unchanged
    cmd(OPC_SHL, 0, 16'h0000, 0);
    rd(0, v);
    check("sh0_val", v, 16'hFFFF);
    check("sh0_done", done, 1'b1);
    check("sh0_ready", op_ready, 1'b1);

    // LOAD held during SHL is accepted only once the bank is idle
    cmd(OPC_LOAD, 3, 16'h1003, 0);
    cmd(OPC_SHL, 3, 16'h0000, 4);
    op = OPC_LOAD; sel = 1; operand = 16'h1234; shamt = 0; op_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      rd(1, v);
      check($sformatf("hold_acc1_%0d", i), v, 16'h00F0);
    end
    check("hold_ready", op_ready, 1'b1);
    rd(3, v);
    check("shl_val", v, 16'h0030);
    check("shl_carry", carry, 1'b1);
    begin
      int budget;
      budget = 0;
      do begin
        step();
        budget++;
        rd(1, v);
      end while (v != 16'h1234 && budget < 8);
      op_valid = 1'b0;
      check("hold_accept_edges", budget, 1);
      check("hold_acc1", v, 16'h1234);
      check("hold_done", done, 1'b1);
      rd(3, v);
      check("hold_acc3", v, 16'h0030);
    end

    // Reset aborts a shift
    cmd(OPC_LOAD, 0, 16'h0001, 0);
    cmd(OPC_SHL, 0, 16'h0000, 5);
    step();
    step();
    rd(0, v);
    check("abort_mid", v, 16'h0004);
    rst_n = 1'b0;
    #1;
    rd(0, v);
    check("abort_acc0", v, 16'h0000);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_done", done, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("abort_nodone%0d", i), done, 1'b0);
    end
    rd(0, v);
    check("abort_acc0_idle", v, 16'h0000);
    cmd(OPC_LOAD, 0, 16'hA5A5, 0);
    rd(0, v);
    check("post_load", v, 16'hA5A5);
    check("post_done", done, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mu0_acc_bank.md
Name: mu0_acc_bank

Overview:
Parametrised accumulator bank for the MU0 datapath, the generalised successor of the single 16-bit accumulator register. Holds NACC accumulators of WIDTH bits. Executes load, add, sub, and, and multi-cycle shift operations on a selected accumulator, with carry/overflow flags and a valid/ready command handshake. It sits between the ALU result/operand bus and the control FSM, which consumes rd_n/rd_z for branch decisions.

Parameters:
WIDTH, 16, accumulator and operand width in bits (>=4)
NACC, 4, number of accumulators (>=1)
AW, $clog2(NACC) (min 1), select-field width, derived and not overridden
SW, $clog2(WIDTH), shift-amount width, derived

Ports:
clk  in  1  clock; all state updates on the falling edge, as for the rest of the MU0 datapath
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  command present
op_ready  out  1  bank can accept a command (high only in IDLE)
op  in  3  opcode: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 AND, 5 SHL, 6 SHR (logical), 7 ASR
sel  in  AW  target accumulator index
operand  in  WIDTH  operand for LOAD/ADD/SUB/AND
shamt  in  SW  shift count for SHL/SHR/ASR
rd_sel  in  AW  read-port index
rd_data  out  WIDTH  combinational read of accumulator rd_sel
rd_n  out  1  rd_data[WIDTH-1]
rd_z  out  1  rd_data == 0
carry  out  1  carry flag register
ovf  out  1  signed-overflow flag register
done  out  1  one-cycle pulse: command completed

Behaviour:
- Reset (async, any state): all accumulators 0, carry 0, ovf 0, done 0, state IDLE, shift counter 0. op_ready is therefore 1 immediately.
- States: IDLE, SHIFT. A command is accepted on a falling edge where op_valid & op_ready.
- Single-cycle ops (NOP/LOAD/ADD/SUB/AND): the target is written at the accept edge. done is high for the following cycle. The FSM stays in IDLE, so back-to-back commands are accepted on consecutive edges.
- LOAD: acc = operand. AND: acc = acc & operand. Both leave carry and ovf unchanged.
- ADD: acc = acc + operand mod 2^WIDTH. carry = bit WIDTH of the sum. ovf = (a_msb == b_msb) & (r_msb != a_msb).
- SUB: acc = acc - operand. carry = 1 when there is no borrow (acc >= operand, unsigned). ovf = (a_msb != b_msb) & (r_msb != a_msb).
- Shifts, shamt == 0: completes like a single-cycle op. Accumulator and carry are unchanged.
- Shifts, shamt = k > 0: at the accept edge, latch sel/op, load counter = k, go to SHIFT, op_ready = 0.
  - Each SHIFT edge shifts the latched target by one bit and sets carry to the bit shifted out. ovf is unchanged.
  - SHL fills with 0. SHR fills with 0. ASR replicates the msb.
  - The counter decrements each edge. On the edge where the counter goes 1 -> 0, the FSM returns to IDLE and done pulses for the next cycle.
  - Total: the result is final k edges after the accept edge.
- Commands presented while op_ready = 0 are ignored, not queued. The command is accepted on the first edge after the FSM returns to IDLE.
- sel >= NACC (NACC not a power of two): the command is accepted and done pulses. No accumulator or flag changes, and no shift is performed.
- rd_data is purely combinational from the register array. It reflects a write from the edge that just occurred, including intermediate shift values.
- Reset asserted mid-shift aborts the shift: no done pulse, all state cleared.

Decomposition:
- Package mu0_acc_pkg:
  - op_t enum (the 8 opcodes above)
  - state_t enum {IDLE, SHIFT}
  - localparam opcode constants
- Sub-module mu0_acc_alu: combinational. Takes a, b, op and returns result, carry_out, ovf_out, plus carry/ovf write enables. The bank instantiates it once for single-cycle ops and performs the 1-bit shift step inline.

Test Plan:
1. Reset: drive rst_n low mid-traffic -> rd_data of every index = 0x0000, carry 0, ovf 0, op_ready 1, done 0, with no clock edge required.
2. LOAD acc2 = 0x7FFF, then ADD acc2 0x0001 -> 0x8000, carry 0, ovf 1, rd_n 1. Then ADD 0x8000 -> 0x0000, carry 1, ovf 1, rd_z 1. Both done pulses are one cycle each, on consecutive cycles.
3. LOAD acc1 = 0x0005, SUB 0x0007 -> 0xFFFE, carry 0, ovf 0. Then AND 0x00F0 -> 0x00F0, with carry and ovf unchanged.
4. LOAD acc0 = 0x8001, SHR shamt 3 -> op_ready low for 3 cycles.
   - Intermediate values: 0x4000 (carry 1), 0x2000 (carry 0), 0x1000 (carry 0).
   - done pulses once after the third shift edge.
   - Then ASR acc0 = 0x8000 shamt 15 -> 0xFFFF after 15 edges.
5. During a SHL shamt 4 on acc3, hold op_valid with LOAD acc1 = 0x1234 -> acc1 is unchanged until SHL done. The LOAD is accepted on the first edge with op_ready = 1, and acc3 is correct.
6. Start SHL acc0 = 0x0001 shamt 5. Assert rst_n low after 2 shift edges -> acc0 = 0, IDLE, no done pulse. Then LOAD acc0 = 0xA5A5 after reset release succeeds.
